// File: rtl/clic_pkg.sv
// Shared types and helpers for the CLIC arbiter.
// Holds the cliccfg field type, FSM states and level decode.
package clic_pkg;

    typedef logic [3:0] nlbits_t;

    localparam int CTLBITS_DEF = 8;

    typedef enum logic {
        SCAN,
        PRESENT
    } state_e;

    // Keep the top nlbits of ctl, fill the rest with ones; nlbits>8 acts as 8
    function automatic logic [7:0] level_decode(logic [7:0] ctl8, nlbits_t nlbits);
        logic [3:0] n;
        logic [7:0] mask;
        n    = (nlbits > 4'd8) ? 4'd8 : nlbits;
        mask = 8'hFF << (4'd8 - n);
        return (ctl8 & mask) | ~mask;
    endfunction

endpackage

// File: rtl/clic_arbiter_if.sv
// Hart-side interrupt presentation and edge-pending clear bus.
// master = arbiter, slave = hart.
interface clic_arbiter_if #(
    parameter int NUM_INTR = 1024,
    parameter int CTLBITS  = 8
);
    localparam int IDW = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1;

    logic               irq_valid;
    logic [IDW-1:0]     irq_id;
    logic [CTLBITS-1:0] irq_ctl;
    logic [7:0]         irq_level;
    logic               irq_ready;
    logic               clr_valid;
    logic [IDW-1:0]     clr_id;

    modport master (
        output irq_valid, irq_id, irq_ctl, irq_level,
        output clr_valid, clr_id,
        input  irq_ready
    );

    modport slave (
        input  irq_valid, irq_id, irq_ctl, irq_level,
        input  clr_valid, clr_id,
        output irq_ready
    );
endinterface

// File: rtl/clic_chunk_max.sv
// Picks the best of LANES candidates and the incoming running best.
// Incoming best always has a lower index, so it wins ties.
module clic_chunk_max #(
    parameter int LANES = 4,
    parameter int IDW   = 10
) (
    input  logic                       in_valid,
    input  logic [IDW-1:0]             in_id,
    input  logic [7:0]                 in_ctl,
    input  logic [7:0]                 in_lvl,
    input  logic [LANES-1:0]           lane_valid,
    input  logic [LANES-1:0][IDW-1:0]  lane_id,
    input  logic [LANES-1:0][7:0]      lane_ctl,
    input  logic [LANES-1:0][7:0]      lane_lvl,
    output logic                       out_valid,
    output logic [IDW-1:0]             out_id,
    output logic [7:0]                 out_ctl,
    output logic [7:0]                 out_lvl
);

    // Ascending lane order with strict compare keeps the lowest index on ties
    always_comb begin
        out_valid = in_valid;
        out_id    = in_id;
        out_ctl   = in_ctl;
        out_lvl   = in_lvl;
        for (int l = 0; l < LANES; l++) begin
            if (lane_valid[l] && (!out_valid || lane_ctl[l] > out_ctl)) begin
                out_valid = 1'b1;
                out_id    = lane_id[l];
                out_ctl   = lane_ctl[l];
                out_lvl   = lane_lvl[l];
            end
        end
    end

endmodule

// File: rtl/clic_arbiter.sv
// CLIC arbiter: sweeps sources LANES at a time, presents the
// highest-ctl eligible source to the hart and pulses a clear on accept.
module clic_arbiter
    import clic_pkg::*;
#(
    parameter int NUM_INTR = 1024,
    parameter int CTLBITS  = CTLBITS_DEF,
    parameter int LANES    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_INTR-1:0]         clicintip,
    input  logic [NUM_INTR-1:0]         clicintie,
    input  logic [NUM_INTR*CTLBITS-1:0] clicintctl,
    input  logic [3:0]                  nlbits,
    input  logic [7:0]                  mintthresh,
    clic_arbiter_if.master              bus
);

    localparam int IDW = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1;
    localparam int NCH = NUM_INTR / LANES;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    // Left-justify an implemented ctl field to 8 bits, low bits read as 1
    function automatic logic [7:0] justify(logic [CTLBITS-1:0] c);
        logic [7:0] w;
        w = 8'(c) << (8 - CTLBITS);
        return w | ~(8'hFF << (8 - CTLBITS));
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  chunk_q, chunk_d;
    logic           best_valid_q, best_valid_d;
    logic [IDW-1:0] best_id_q, best_id_d;
    logic [7:0]     best_ctl_q, best_ctl_d;
    logic [7:0]     best_lvl_q, best_lvl_d;
    logic           irq_valid_q, irq_valid_d;
    logic [IDW-1:0] irq_id_q, irq_id_d;
    logic [7:0]     irq_ctl_q, irq_ctl_d;
    logic [7:0]     irq_lvl_q, irq_lvl_d;
    logic           clr_valid_q, clr_valid_d;
    logic [IDW-1:0] clr_id_q, clr_id_d;

    logic [LANES-1:0]          lane_valid;
    logic [LANES-1:0][IDW-1:0] lane_id;
    logic [LANES-1:0][7:0]     lane_ctl;
    logic [LANES-1:0][7:0]     lane_lvl;
    logic                      m_valid;
    logic [IDW-1:0]            m_id;
    logic [7:0]                m_ctl;
    logic [7:0]                m_lvl;

    // Qualify the sources of the current chunk against live inputs
    always_comb begin
        int idx;
        idx        = 0;
        lane_valid = '0;
        lane_id    = '0;
        lane_ctl   = '0;
        lane_lvl   = '0;
        for (int l = 0; l < LANES; l++) begin
            idx           = int'(chunk_q) * LANES + l;
            lane_id[l]    = IDW'(idx);
            lane_ctl[l]   = justify(clicintctl[idx*CTLBITS +: CTLBITS]);
            lane_lvl[l]   = level_decode(lane_ctl[l], nlbits);
            lane_valid[l] = clicintip[idx] & clicintie[idx]
                          & (lane_lvl[l] > mintthresh);
        end
    end

    clic_chunk_max #(
        .LANES (LANES),
        .IDW   (IDW)
    ) u_chunk_max (
        .in_valid   (best_valid_q),
        .in_id      (best_id_q),
        .in_ctl     (best_ctl_q),
        .in_lvl     (best_lvl_q),
        .lane_valid (lane_valid),
        .lane_id    (lane_id),
        .lane_ctl   (lane_ctl),
        .lane_lvl   (lane_lvl),
        .out_valid  (m_valid),
        .out_id     (m_id),
        .out_ctl    (m_ctl),
        .out_lvl    (m_lvl)
    );

    // Sweep/present FSM next-state; handshake takes priority over withdrawal
    always_comb begin
        state_d      = state_q;
        chunk_d      = chunk_q;
        best_valid_d = best_valid_q;
        best_id_d    = best_id_q;
        best_ctl_d   = best_ctl_q;
        best_lvl_d   = best_lvl_q;
        irq_valid_d  = irq_valid_q;
        irq_id_d     = irq_id_q;
        irq_ctl_d    = irq_ctl_q;
        irq_lvl_d    = irq_lvl_q;
        clr_valid_d  = 1'b0;
        clr_id_d     = clr_id_q;
        unique case (state_q)
            SCAN: begin
                if (chunk_q == CW'(NCH - 1)) begin
                    chunk_d      = '0;
                    best_valid_d = 1'b0;
                    best_id_d    = '0;
                    best_ctl_d   = '0;
                    best_lvl_d   = '0;
                    if (m_valid) begin
                        state_d     = PRESENT;
                        irq_valid_d = 1'b1;
                        irq_id_d    = m_id;
                        irq_ctl_d   = m_ctl;
                        irq_lvl_d   = m_lvl;
                    end
                end else begin
                    chunk_d      = CW'(chunk_q + 1'b1);
                    best_valid_d = m_valid;
                    best_id_d    = m_id;
                    best_ctl_d   = m_ctl;
                    best_lvl_d   = m_lvl;
                end
            end
            PRESENT: begin
                if (irq_valid_q && bus.irq_ready) begin
                    clr_valid_d = 1'b1;
                    clr_id_d    = irq_id_q;
                    irq_valid_d = 1'b0;
                    state_d     = SCAN;
                    chunk_d     = '0;
                end else if (!clicintip[irq_id_q] || !clicintie[irq_id_q]) begin
                    irq_valid_d = 1'b0;
                    state_d     = SCAN;
                    chunk_d     = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // All arbiter state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SCAN;
            chunk_q      <= '0;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_ctl_q   <= '0;
            best_lvl_q   <= '0;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            irq_ctl_q    <= '0;
            irq_lvl_q    <= '0;
            clr_valid_q  <= 1'b0;
            clr_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            chunk_q      <= chunk_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            best_ctl_q   <= best_ctl_d;
            best_lvl_q   <= best_lvl_d;
            irq_valid_q  <= irq_valid_d;
            irq_id_q     <= irq_id_d;
            irq_ctl_q    <= irq_ctl_d;
            irq_lvl_q    <= irq_lvl_d;
            clr_valid_q  <= clr_valid_d;
            clr_id_q     <= clr_id_d;
        end
    end

    assign bus.irq_valid = irq_valid_q;
    assign bus.irq_id    = irq_id_q;
    assign bus.irq_ctl   = CTLBITS'(irq_ctl_q >> (8 - CTLBITS));
    assign bus.irq_level = irq_lvl_q;
    assign bus.clr_valid = clr_valid_q;
    assign bus.clr_id    = clr_id_q;

endmodule

// File: tb/tb_clic_arbiter.sv
// Directed and randomized bench for clic_arbiter (16 sources, 4 lanes).
// Expected winners come from a whole-array reference model.
module tb_clic_arbiter;

    localparam int N  = 16;
    localparam int L  = 4;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  ip  = '0;
    logic [N-1:0]  ie  = '0;
    logic [N*CB-1:0] ctl = '0;
    logic [3:0]    nl  = 4'd5;
    logic [7:0]    th  = 8'd0;

    int tests = 0;
    int fails = 0;

    clic_arbiter_if #(.NUM_INTR(N), .CTLBITS(CB)) bus ();

    clic_arbiter #(
        .NUM_INTR (N),
        .CTLBITS  (CB),
        .LANES    (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clicintip  (ip),
        .clicintie  (ie),
        .clicintctl (ctl),
        .nlbits     (nl),
        .mintthresh (th),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lvl_of(input int c, input int n);
        if (n > 8) n = 8;
        return c | (255 >> n);
    endfunction

    // Reference: scan the whole array, keep the first strictly larger ctl
    task automatic model(output bit v, output int id, output int c, output int lv);
        int ci, li;
        v = 0; id = 0; c = 0; lv = 0;
        for (int i = 0; i < N; i++) begin
            ci = int'(ctl[i*CB +: CB]);
            li = lvl_of(ci, int'(nl));
            if (ip[i] && ie[i] && li > int'(th) && (!v || ci > c)) begin
                v = 1; id = i; c = ci; lv = li;
            end
        end
    endtask

    task automatic set_src(input int i, input int c);
        ctl[i*CB +: CB] = c[7:0];
        ip[i] = 1'b1;
        ie[i] = 1'b1;
    endtask

    task automatic clear_all();
        ip = '0; ie = '0; ctl = '0;
    endtask

    task automatic restart();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Winner must appear exactly after one full sweep, with no clear pulse
    task automatic expect_present(input string tag, input int id, input int c, input int lv);
        bit early;
        early = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.irq_valid !== 1'b0 || bus.clr_valid !== 1'b0) early = 1;
        end
        chk({tag, "_early"}, 32'(early), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(bus.irq_valid), 32'd1);
        chk({tag, "_id"}, 32'(bus.irq_id), 32'(id));
        chk({tag, "_ctl"}, 32'(bus.irq_ctl), 32'(c));
        chk({tag, "_lvl"}, 32'(bus.irq_level), 32'(lv));
    endtask

    task automatic wait_valid(input int max, output bit got);
        got = 0;
        for (int k = 0; k < max && !got; k++) begin
            step();
            if (bus.irq_valid === 1'b1) got = 1;
        end
    endtask

    initial begin
        bit got, bad, v;
        int mid, mc, ml, sel;

        bus.irq_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.irq_valid), 32'd0);
        chk("rst_clr", 32'(bus.clr_valid), 32'd0);
        chk("rst_id", 32'(bus.irq_id), 32'd0);
        chk("rst_ctl", 32'(bus.irq_ctl), 32'd0);
        chk("rst_lvl", 32'(bus.irq_level), 32'd0);
        chk("rst_clrid", 32'(bus.clr_id), 32'd0);
        step();

        set_src(5, 'hA0);
        rst = 1'b0;
        expect_present("single", 5, 'hA0, 'hA7);

        set_src(9, 'hFF);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.irq_valid !== 1'b1 || bus.irq_id !== 4'd5) bad = 1;
        end
        chk("no_preempt", 32'(bad), 32'd0);

        bus.irq_ready = 1'b1;
        step();
        bus.irq_ready = 1'b0;
        chk("hs_clr", 32'(bus.clr_valid), 32'd1);
        chk("hs_clrid", 32'(bus.clr_id), 32'd5);
        chk("hs_valid", 32'(bus.irq_valid), 32'd0);
        ip[5] = 1'b0;
        step();
        chk("hs_pulse", 32'(bus.clr_valid), 32'd0);
        wait_valid(8, got);
        chk("next_got", 32'(got), 32'd1);
        chk("next_id", 32'(bus.irq_id), 32'd9);
        chk("next_lvl", 32'(bus.irq_level), 32'hFF);

        clear_all();
        restart();
        bus.irq_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.clr_valid !== 1'b0 || bus.irq_valid !== 1'b0) bad = 1;
        end
        bus.irq_ready = 1'b0;
        chk("idle_ready", 32'(bad), 32'd0);

        clear_all();
        set_src(3, 'hC8);
        set_src(12, 'hC8);
        restart();
        expect_present("tie", 3, 'hC8, 'hCF);
        set_src(12, 'hD0);
        restart();
        expect_present("hi12", 12, 'hD0, 'hD7);

        clear_all();
        set_src(5, 'hA0);
        restart();
        expect_present("pre_wd", 5, 'hA0, 'hA7);
        ie[5] = 1'b0;
        step();
        chk("wd_valid", 32'(bus.irq_valid), 32'd0);
        chk("wd_clr", 32'(bus.clr_valid), 32'd0);
        ie[5] = 1'b1;
        expect_present("rescan", 5, 'hA0, 'hA7);

        clear_all();
        set_src(5, 'hA0);
        th = 8'hA7;
        restart();
        wait_valid(12, got);
        chk("th_block", 32'(got), 32'd0);
        th = 8'hA6;
        wait_valid(8, got);
        chk("th_pass", 32'(got), 32'd1);
        chk("th_id", 32'(bus.irq_id), 32'd5);
        th = 8'd0;

        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.irq_valid), 32'd0);
        chk("arst_clr", 32'(bus.clr_valid), 32'd0);
        step();
        rst = 1'b0;
        expect_present("post_rst", 5, 'hA0, 'hA7);

        for (int it = 0; it < 25; it++) begin
            ip = 16'($urandom);
            ie = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: ctl[i*CB +: CB] = 8'h40;
                    1: ctl[i*CB +: CB] = 8'hA0;
                    2: ctl[i*CB +: CB] = 8'hC8;
                    3: ctl[i*CB +: CB] = 8'hFF;
                    default: ctl[i*CB +: CB] = 8'($urandom);
                endcase
            end
            nl = 4'($urandom_range(0, 9));
            th = 8'($urandom_range(0, 220));
            model(v, mid, mc, ml);
            restart();
            for (int k = 0; k < 4; k++) step();
            chk($sformatf("rnd%0d_valid", it), 32'(bus.irq_valid), 32'(v));
            if (v) begin
                chk($sformatf("rnd%0d_id", it), 32'(bus.irq_id), 32'(mid));
                chk($sformatf("rnd%0d_ctl", it), 32'(bus.irq_ctl), 32'(mc));
                chk($sformatf("rnd%0d_lvl", it), 32'(bus.irq_level), 32'(ml));
                bus.irq_ready = 1'b1;
                step();
                bus.irq_ready = 1'b0;
                chk($sformatf("rnd%0d_clr", it), 32'(bus.clr_valid), 32'd1);
                chk($sformatf("rnd%0d_clrid", it), 32'(bus.clr_id), 32'(mid));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
